// File: rtl/gor_16.sv
// gor_16 -- WIDTH-bit bitwise OR unit with combinational and registered outputs.
//
// Purpose:
//   o_y is the combinational a | b.
//   o_y_q holds the result of the most recent cycle in which i_in_valid was high.
//   o_out_valid pulses for one cycle after each captured operation.
//
// Ports:
//   i_clk        system clock; all registers update on its rising edge
//   i_rst        synchronous reset, active-high; overrides i_in_valid
//   i_a, i_b     WIDTH-bit operands (unsigned bit vectors)
//   i_in_valid   qualifies i_a/i_b for capture into the registered path
//   o_y          combinational result, i_a | i_b
//   o_y_q        registered result; holds its value when i_in_valid is low
//   o_out_valid  high for one cycle after each captured operation
//   o_zero_q     (GOR16_FLAGS_EN only) captured result was all zeros
//   o_ones_q     (GOR16_FLAGS_EN only) captured result was all ones
//
// Build option:
//   GOR16_FLAGS_EN  adds the o_zero_q / o_ones_q flag outputs and their registers.

module gor_16 #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_in_valid,
   output logic [WIDTH-1:0] o_y,
   output logic [WIDTH-1:0] o_y_q,
   output logic             o_out_valid
`ifdef GOR16_FLAGS_EN
   ,
   output logic             o_zero_q,
   output logic             o_ones_q
`endif
);

   logic [WIDTH-1:0] w_or;
   logic [WIDTH-1:0] r_y_q;
   logic             r_out_valid;

   // Plain OR keeps the standard X rules on the combinational path (1|X=1, 0|X=X).
   assign w_or = i_a | i_b;
   assign o_y  = w_or;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_y_q       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= i_in_valid;
         if (i_in_valid) begin
            r_y_q <= w_or;
         end
      end
   end

   assign o_y_q       = r_y_q;
   assign o_out_valid = r_out_valid;

`ifdef GOR16_FLAGS_EN
   logic r_zero_q;
   logic r_ones_q;

   // Flags reset to 0 even though the reset result is zero: they describe the
   // last captured operation, and after reset there is none.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_zero_q <= 1'b0;
         r_ones_q <= 1'b0;
      end else if (i_in_valid) begin
         r_zero_q <= (w_or == '0);
         r_ones_q <= &w_or;
      end
   end

   assign o_zero_q = r_zero_q;
   assign o_ones_q = r_ones_q;
`endif

endmodule

// File: tb/tb_gor_16.sv
module tb_gor_16;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic        in_valid;
   logic [15:0] y;
   logic [15:0] y_q;
   logic        out_valid;
   logic        zero_q;
   logic        ones_q;

   int n_vec;
   int n_err;

   logic [15:0] m_y_q;
   logic        m_zero;
   logic        m_ones;

   gor_16 #(.WIDTH(16)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_a         (a),
      .i_b         (b),
      .i_in_valid  (in_valid),
      .o_y         (y),
      .o_y_q       (y_q),
      .o_out_valid (out_valid)
`ifdef GOR16_FLAGS_EN
      ,
      .o_zero_q    (zero_q),
      .o_ones_q    (ones_q)
`endif
   );

`ifndef GOR16_FLAGS_EN
   assign zero_q = 1'b0;
   assign ones_q = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs driven here are stable for the next one.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b1;
      a        = '0;
      b        = '0;
      in_valid = 1'b0;

      // Reset for two cycles
      tick();
      tick();
      chk("rst_y_q", y_q, 16'h0000);
      chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
`ifdef GOR16_FLAGS_EN
      chk("rst_zero_q", {15'd0, zero_q}, 16'd0);
      chk("rst_ones_q", {15'd0, ones_q}, 16'd0);
`endif
      rst = 1'b0;

      // Combinational truth table, no clock dependency
      a = 16'd0; b = 16'd0; #10; chk("comb_0_0", y, 16'd0);
      a = 16'd0; b = 16'd1; #10; chk("comb_0_1", y, 16'd1);
      a = 16'd1; b = 16'd0; #10; chk("comb_1_0", y, 16'd1);
      a = 16'd1; b = 16'd1; #10; chk("comb_1_1", y, 16'd1);
      a = 16'hFFFF; b = 16'h0000; #10; chk("comb_ones", y, 16'hFFFF);
      tick();
      chk("idle_y_q", y_q, 16'h0000);
      chk("idle_out_valid", {15'd0, out_valid}, 16'd0);

      // Single capture
      a = 16'hA5A5; b = 16'h5A5A; in_valid = 1'b1;
      #1;
      chk("a5_comb", y, 16'hFFFF);
      tick();
      in_valid = 1'b0;
      chk("a5_y_q", y_q, 16'hFFFF);
      chk("a5_out_valid", {15'd0, out_valid}, 16'd1);
`ifdef GOR16_FLAGS_EN
      chk("a5_ones_q", {15'd0, ones_q}, 16'd1);
      chk("a5_zero_q", {15'd0, zero_q}, 16'd0);
`endif
      tick();
      chk("a5_hold_y_q", y_q, 16'hFFFF);
      chk("a5_hold_out_valid", {15'd0, out_valid}, 16'd0);
`ifdef GOR16_FLAGS_EN
      chk("a5_hold_ones_q", {15'd0, ones_q}, 16'd1);
`endif

      // Back-to-back captures
      a = 16'h00F0; b = 16'h0F00; in_valid = 1'b1;
      tick();
      chk("b2b0_y_q", y_q, 16'h0FF0);
      chk("b2b0_out_valid", {15'd0, out_valid}, 16'd1);
`ifdef GOR16_FLAGS_EN
      chk("b2b0_ones_q", {15'd0, ones_q}, 16'd0);
      chk("b2b0_zero_q", {15'd0, zero_q}, 16'd0);
`endif
      a = 16'h0000; b = 16'h0000;
      tick();
      in_valid = 1'b0;
      chk("b2b1_y_q", y_q, 16'h0000);
      chk("b2b1_out_valid", {15'd0, out_valid}, 16'd1);
`ifdef GOR16_FLAGS_EN
      chk("b2b1_zero_q", {15'd0, zero_q}, 16'd1);
`endif
      tick();
      chk("b2b_end_out_valid", {15'd0, out_valid}, 16'd0);

      // Reset overrides a valid on the same edge, dropping a non-zero held result
      a = 16'hFFFF; b = 16'h0000; in_valid = 1'b1;
      tick();
      chk("pre_rst_y_q", y_q, 16'hFFFF);
      a = 16'h1234; b = 16'h0001; rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_ovr_y_q", y_q, 16'h0000);
      chk("rst_ovr_out_valid", {15'd0, out_valid}, 16'd0);
`ifdef GOR16_FLAGS_EN
      chk("rst_ovr_ones_q", {15'd0, ones_q}, 16'd0);
      chk("rst_ovr_zero_q", {15'd0, zero_q}, 16'd0);
`endif

      // Random traffic against a reference model
      m_y_q  = 16'h0000;
      m_zero = 1'b0;
      m_ones = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         a        = 16'($urandom);
         b        = 16'($urandom);
         if (i % 97 == 5) a = 16'hFFFF;
         if (i % 89 == 7) begin a = 16'h0000; b = 16'h0000; end
         in_valid = 1'($urandom_range(0, 1));
         #1;
         chk("rnd_y", y, a | b);
         if (in_valid) begin
            m_y_q  = a | b;
            m_zero = ((a | b) == 16'h0000);
            m_ones = ((a | b) == 16'hFFFF);
         end
         tick();
         chk("rnd_y_q", y_q, m_y_q);
         chk("rnd_out_valid", {15'd0, out_valid}, {15'd0, in_valid});
`ifdef GOR16_FLAGS_EN
         chk("rnd_zero_q", {15'd0, zero_q}, {15'd0, m_zero});
         chk("rnd_ones_q", {15'd0, ones_q}, {15'd0, m_ones});
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gor_16.md
Name: gor_16

Overview:
- 16-bit bitwise OR unit: y = a | b.
- Provides a combinational result and a one-cycle registered copy with a valid flag.
- Leaf datapath element in the combinational-gate library, usable directly or inside pipelined ALU datapaths.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be at least 1; all behaviour below holds for any WIDTH.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- rst  input  1  synchronous reset, active-high; takes effect on the rising edge of clk.
- a  input  WIDTH  operand A, unsigned bit vector.
- b  input  WIDTH  operand B, unsigned bit vector.
- in_valid  input  1  qualifies a/b for capture into the registered path.
- y  output  WIDTH  combinational result, a | b.
- y_q  output  WIDTH  registered result.
- out_valid  output  1  high for one cycle after each captured operation.

Behaviour:
- Combinational path:
  - y = a | b, bit-for-bit.
  - No clock or reset dependency; y follows input changes within the same delta/cycle.
  - y is valid whenever a and b are driven.
  - X/Z on an input bit propagates per the standard OR rules: 1|X=1, 0|X=X.
- Registered path, on each rising clk edge:
  - rst=1: y_q <= 0 and out_valid <= 0. Reset overrides in_valid.
  - rst=0, in_valid=1: y_q <= a | b and out_valid <= 1.
  - rst=0, in_valid=0: y_q holds its previous value and out_valid <= 0.
- Latency is exactly 1 cycle from in_valid sampled high to out_valid high with the matching y_q.
- Back-to-back in_valid gives one result per cycle. No backpressure and no stall input.
- Reset asserted mid-stream drops the in-flight result: the following cycle shows out_valid=0 and y_q=0.
- Edge values:
  - a=0, b=0 gives y=0.
  - Any operand all-ones gives an all-ones result.
  - No carry, no overflow, no sign interpretation; the result is always exactly WIDTH bits.
- Before the first reset, register contents are unspecified. A bench must apply reset before checking y_q or out_valid.

Optional Feature:
- Macro GOR16_FLAGS_EN.
- When defined, two extra outputs are added, both registered alongside y_q:
  - zero_q (1 bit): 1 when the captured a|b == 0.
  - ones_q (1 bit): 1 when the captured a|b is all ones.
  - Both update only when in_valid=1 and hold otherwise.
  - Both reset to 0. Note that zero_q resets to 0 even though y_q resets to 0.
- When the macro is undefined:
  - The ports zero_q and ones_q do not exist.
  - No flag logic is generated.
  - All other behaviour is identical.

Test Plan:
- Apply rst=1 for 2 cycles, then rst=0 -> y_q=0, out_valid=0. With GOR16_FLAGS_EN: zero_q=0, ones_q=0.
- a=0,b=0 -> y=0. Then a=0,b=1 -> y=1. Then a=1,b=0 -> y=1. Then a=1,b=1 -> y=1. Check each combinationally, 10 time units apart, with no clock required.
- a=16'hA5A5, b=16'h5A5A, in_valid=1 for one cycle -> y=16'hFFFF immediately; next cycle y_q=16'hFFFF, out_valid=1 (ones_q=1 with flags). The cycle after: out_valid=0 and y_q holds 16'hFFFF.
- Back-to-back in_valid, sending (16'h00F0|16'h0F00) then (16'h0000|16'h0000) -> y_q=16'h0FF0 then 16'h0000 on consecutive cycles, out_valid high both cycles (zero_q=1 on the second with flags).
- in_valid=1 with a=16'h1234, b=16'h0001, and rst=1 on the same edge -> y_q=0, out_valid=0.
- 1000 random a/b pairs with random in_valid -> y == a|b every cycle, and y_q equals a|b from the last valid-qualified cycle.
